// File: rtl/periph_arbiter_if.sv
// Bundle between two bus masters, the arbiter and the single peripheral slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding masters and peripheral.
interface periph_arbiter_if #(
    parameter int AW = 22,
    parameter int DW = 32,
    parameter int BW = 4
);
    logic [2*AW-1:0] m_read_addr;
    logic [1:0]      m_oe;
    logic [2*AW-1:0] m_write_addr;
    logic [2*DW-1:0] m_data_in;
    logic [2*BW-1:0] m_be;
    logic [1:0]      m_we;
    logic [DW-1:0]   m_data_out;
    logic [1:0]      m_data_valid;
    logic [1:0]      m_wack;

    logic [AW-1:0]   s_read_addr;
    logic            s_oe;
    logic [AW-1:0]   s_write_addr;
    logic            s_we;
    logic [DW-1:0]   s_data_in;
    logic [BW-1:0]   s_be;
    logic [DW-1:0]   s_data_out;
    logic            s_data_valid;
    logic            s_wack;
    logic            timeout_err;

    modport slave (
        input  m_read_addr, m_oe, m_write_addr, m_data_in, m_be, m_we,
        input  s_data_out, s_data_valid, s_wack,
        output m_data_out, m_data_valid, m_wack,
        output s_read_addr, s_oe, s_write_addr, s_we, s_data_in, s_be, timeout_err
    );

    modport master (
        output m_read_addr, m_oe, m_write_addr, m_data_in, m_be, m_we,
        output s_data_out, s_data_valid, s_wack,
        input  m_data_out, m_data_valid, m_wack,
        input  s_read_addr, s_oe, s_write_addr, s_we, s_data_in, s_be, timeout_err
    );
endinterface

// File: rtl/periph_arbiter.sv
// Round-robin arbiter sharing one peripheral port between two masters, one transaction in flight,
// with a watchdog that force-completes unanswered accesses. 1-cycle slave: request N -> pulse N+3.
module periph_arbiter #(
    parameter int address_width  = 22,
    parameter int data_width     = 2,
    parameter int timeout_cycles = 16
) (
    input  logic            clk,
    input  logic            rst,
    periph_arbiter_if.slave bus
);
    localparam int AW = address_width;
    localparam int DW = (1 << data_width) * 8;
    localparam int BW = 1 << data_width;
    localparam int CW = $clog2(timeout_cycles + 1);
    localparam logic [CW-1:0] TLAST = CW'(timeout_cycles - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic          last_grant;
    logic          gnt;
    logic          op_wr;
    logic          op_null;
    logic [CW-1:0] tcnt;

    logic [1:0]    req;
    logic          sel;
    logic          sel_we;
    logic [AW-1:0] sel_raddr;
    logic [AW-1:0] sel_waddr;
    logic [DW-1:0] sel_wdata;
    logic [BW-1:0] sel_be;
    logic [1:0]    gnt_mask;
    logic          rsp;

    always_comb begin
        req       = bus.m_oe | bus.m_we;
        sel       = (req == 2'b11) ? ~last_grant : req[1];
        sel_we    = sel ? bus.m_we[1] : bus.m_we[0];
        sel_raddr = sel ? bus.m_read_addr[2*AW-1:AW]  : bus.m_read_addr[AW-1:0];
        sel_waddr = sel ? bus.m_write_addr[2*AW-1:AW] : bus.m_write_addr[AW-1:0];
        sel_wdata = sel ? bus.m_data_in[2*DW-1:DW]    : bus.m_data_in[DW-1:0];
        sel_be    = sel ? bus.m_be[2*BW-1:BW]         : bus.m_be[BW-1:0];
        gnt_mask  = gnt ? 2'b10 : 2'b01;
        // only the response matching the pending op type counts
        rsp       = op_wr ? bus.s_wack : bus.s_data_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            gnt              <= 1'b0;
            op_wr            <= 1'b0;
            op_null          <= 1'b0;
            tcnt             <= '0;
            bus.m_data_out   <= '0;
            bus.m_data_valid <= '0;
            bus.m_wack       <= '0;
            bus.s_read_addr  <= '0;
            bus.s_write_addr <= '0;
            bus.s_data_in    <= '0;
            bus.s_be         <= '0;
            bus.s_oe         <= 1'b0;
            bus.s_we         <= 1'b0;
            bus.timeout_err  <= 1'b0;
        end else begin
            bus.m_data_out   <= '0;
            bus.m_data_valid <= '0;
            bus.m_wack       <= '0;
            bus.s_oe         <= 1'b0;
            bus.s_we         <= 1'b0;
            bus.timeout_err  <= 1'b0;
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (req != 2'b00) begin
                        gnt              <= sel;
                        last_grant       <= sel;
                        op_wr            <= sel_we;
                        op_null          <= sel_we && (sel_be == '0);
                        bus.s_read_addr  <= sel_raddr;
                        bus.s_write_addr <= sel_waddr;
                        bus.s_data_in    <= sel_wdata;
                        bus.s_be         <= sel_be;
                        bus.s_oe         <= ~sel_we;
                        bus.s_we         <= sel_we && (sel_be != '0);
                        state            <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (op_null) begin
                        bus.m_wack <= gnt_mask;
                        state      <= RESP;
                    end else if (rsp) begin
                        bus.m_data_out <= bus.s_data_out;
                        if (op_wr) bus.m_wack <= gnt_mask;
                        else       bus.m_data_valid <= gnt_mask;
                        state <= RESP;
                    end else if (tcnt == TLAST) begin
                        bus.m_data_out  <= '1;
                        bus.timeout_err <= 1'b1;
                        if (op_wr) bus.m_wack <= gnt_mask;
                        else       bus.m_data_valid <= gnt_mask;
                        state <= RESP;
                    end else begin
                        tcnt  <= tcnt + CW'(1);
                        state <= WAIT;
                    end
                end
                RESP: begin
                    bus.s_read_addr  <= '0;
                    bus.s_write_addr <= '0;
                    bus.s_data_in    <= '0;
                    bus.s_be         <= '0;
                    op_null          <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_periph_arbiter.sv
// Directed bench for periph_arbiter: transaction vector table, a configurable-delay slave model,
// and hand-written sequences for arbitration fairness, reset mid-transaction and WE+OE ordering.
module tb_periph_arbiter;
    localparam int AW = 22;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    periph_arbiter_if #(.AW(AW), .DW(DW), .BW(BW)) bus ();

    periph_arbiter #(.address_width(22), .data_width(2), .timeout_cycles(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // slave model: answers a strobe after slv_dly cycles (0 = never); slv_swap answers with the wrong type
    int   slv_dly  = 0;
    logic slv_swap = 1'b0;
    int   pend     = 0;
    logic pend_rd  = 1'b0;

    always @(posedge clk) begin
        bus.s_data_valid <= 1'b0;
        bus.s_wack       <= 1'b0;
        if (rst) begin
            pend <= 0;
        end else begin
            if (pend == 1) begin
                if (pend_rd ^ slv_swap) bus.s_data_valid <= 1'b1;
                else                    bus.s_wack       <= 1'b1;
            end
            if (pend > 0) pend <= pend - 1;
            if ((bus.s_oe || bus.s_we) && slv_dly > 0) begin
                if (slv_dly == 1) begin
                    if (bus.s_oe ^ slv_swap) bus.s_data_valid <= 1'b1;
                    else                     bus.s_wack       <= 1'b1;
                end else begin
                    pend    <= slv_dly - 1;
                    pend_rd <= bus.s_oe;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_s_oe"},         bus.s_oe,         0);
        chk({tag, "_s_we"},         bus.s_we,         0);
        chk({tag, "_s_read_addr"},  bus.s_read_addr,  0);
        chk({tag, "_s_write_addr"}, bus.s_write_addr, 0);
        chk({tag, "_s_data_in"},    bus.s_data_in,    0);
        chk({tag, "_s_be"},         bus.s_be,         0);
        chk({tag, "_m_data_out"},   bus.m_data_out,   0);
        chk({tag, "_m_data_valid"}, bus.m_data_valid, 0);
        chk({tag, "_m_wack"},       bus.m_wack,       0);
        chk({tag, "_timeout_err"},  bus.timeout_err,  0);
    endtask

    // observation results, cycle k=1 is the cycle after the request was presented
    int            npulse, n_oe, n_we, oe_cyc, we_cyc, stray;
    logic [AW-1:0] oe_addr, we_addr;
    logic [DW-1:0] we_data;
    logic [BW-1:0] we_be;
    int            p_cyc   [8];
    logic [1:0]    p_valid [8];
    logic [1:0]    p_wack  [8];
    logic [DW-1:0] p_data  [8];
    logic          p_terr  [8];

    task automatic observe(input int win);
        npulse = 0; n_oe = 0; n_we = 0; oe_cyc = 0; we_cyc = 0; stray = 0;
        for (int k = 1; k <= win; k++) begin
            @(negedge clk);
            if (bus.s_oe) begin
                n_oe++;
                if (oe_cyc == 0) begin oe_cyc = k; oe_addr = bus.s_read_addr; end
            end
            if (bus.s_we) begin
                n_we++;
                if (we_cyc == 0) begin
                    we_cyc = k; we_addr = bus.s_write_addr; we_data = bus.s_data_in; we_be = bus.s_be;
                end
            end
            if (bus.m_data_valid != 2'b00 || bus.m_wack != 2'b00) begin
                if (npulse < 8) begin
                    p_cyc[npulse]   = k;
                    p_valid[npulse] = bus.m_data_valid;
                    p_wack[npulse]  = bus.m_wack;
                    p_data[npulse]  = bus.m_data_out;
                    p_terr[npulse]  = bus.timeout_err;
                end
                npulse++;
                for (int m = 0; m < 2; m++) begin
                    if (bus.m_data_valid[m]) bus.m_oe[m] = 1'b0;
                    if (bus.m_wack[m])       bus.m_we[m] = 1'b0;
                end
            end else if (bus.m_data_out != '0 || bus.timeout_err) begin
                stray++;
            end
        end
    endtask

    typedef struct {
        logic          m;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        logic [DW-1:0] sdata;
        int            dly;
        logic          swap;
        int            e_cyc;
        logic [1:0]    e_mask;
        logic [DW-1:0] e_data;
        logic          e_terr;
        int            e_oe;
        int            e_we;
    } vec_t;

    vec_t vecs[10];

    // grant log for the arbitration sequences
    int   g_m  [8];
    logic g_rd [8];
    int   g_n;

    task automatic arb_run(input int n, input bit rearm);
        bit again[2];
        again[0] = 1'b0; again[1] = 1'b0;
        g_n = 0;
        for (int k = 0; k < 80 && g_n < n; k++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (again[m]) begin bus.m_oe[m] = 1'b1; again[m] = 1'b0; end
            end
            for (int m = 0; m < 2; m++) begin
                if ((bus.m_data_valid[m] || bus.m_wack[m]) && g_n < 8) begin
                    g_m[g_n]  = m;
                    g_rd[g_n] = bus.m_data_valid[m];
                    g_n++;
                    if (bus.m_data_valid[m]) bus.m_oe[m] = 1'b0;
                    if (bus.m_wack[m])       bus.m_we[m] = 1'b0;
                    again[m] = rearm;
                end
            end
        end
        bus.m_oe = 2'b00;
        bus.m_we = 2'b00;
        chk("arb_grant_count", g_n, n);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 22'h000100, 32'h0, 4'h0, 32'h0000DEAD, 1,  1'b0, 3,  2'b01, 32'h0000DEAD, 1'b0, 1, 0};
        vecs[1] = '{1'b1, 1'b0, 22'h3FFFFF, 32'h12345678, 4'hF, 32'h0, 1,  1'b0, 3,  2'b10, 32'h0, 1'b0, 0, 1};
        vecs[2] = '{1'b1, 1'b0, 22'h001234, 32'hAAAA5555, 4'h0, 32'h0, 1,  1'b0, 2,  2'b10, 32'h0, 1'b0, 0, 0};
        vecs[3] = '{1'b0, 1'b1, 22'h000040, 32'h0, 4'h0, 32'h11111111, 0,  1'b0, 17, 2'b01, 32'hFFFFFFFF, 1'b1, 1, 0};
        vecs[4] = '{1'b0, 1'b1, 22'h000044, 32'h0, 4'h0, 32'h22222222, 19, 1'b0, 17, 2'b01, 32'hFFFFFFFF, 1'b1, 1, 0};
        vecs[5] = '{1'b1, 1'b1, 22'h2AAAAA, 32'h0, 4'h0, 32'h33333333, 15, 1'b0, 17, 2'b10, 32'h33333333, 1'b0, 1, 0};
        vecs[6] = '{1'b0, 1'b1, 22'h155555, 32'h0, 4'h0, 32'h44444444, 16, 1'b0, 17, 2'b01, 32'hFFFFFFFF, 1'b1, 1, 0};
        vecs[7] = '{1'b0, 1'b0, 22'h000008, 32'hDEADBEEF, 4'h5, 32'h0, 3,  1'b0, 5,  2'b01, 32'h0, 1'b0, 0, 1};
        vecs[8] = '{1'b1, 1'b1, 22'h000010, 32'h0, 4'h0, 32'h55555555, 1,  1'b1, 17, 2'b10, 32'hFFFFFFFF, 1'b1, 1, 0};
        vecs[9] = '{1'b0, 1'b0, 22'h000020, 32'h0BADF00D, 4'h8, 32'h0, 0,  1'b0, 17, 2'b01, 32'h0, 1'b1, 0, 1};

        bus.m_read_addr = '0; bus.m_write_addr = '0; bus.m_data_in = '0;
        bus.m_be = '0; bus.m_oe = 2'b00; bus.m_we = 2'b00; bus.s_data_out = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // from reset: M0 write and M1 read together -> M0 first, then M1
        slv_dly = 1; slv_swap = 1'b0;
        bus.m_write_addr[AW-1:0] = 22'h000777; bus.m_data_in[DW-1:0] = 32'h01020304;
        bus.m_be[BW-1:0] = 4'hF; bus.m_read_addr[2*AW-1:AW] = 22'h000888;
        bus.m_we = 2'b01; bus.m_oe = 2'b10;
        arb_run(2, 1'b0);
        chk("arb1_first_m",  g_m[0],  0);
        chk("arb1_first_rd", g_rd[0], 0);
        chk("arb1_second_m", g_m[1],  1);
        chk("arb1_second_rd", g_rd[1], 1);

        // both keep re-requesting reads -> strict alternation starting with M0
        bus.m_oe = 2'b11;
        arb_run(4, 1'b1);
        for (int i = 0; i < 4; i++) chk($sformatf("arb2_round%0d_m", i), g_m[i], i % 2);

        for (int i = 0; i < 10; i++) begin
            int   mi;
            vec_t v;
            v  = vecs[i];
            mi = int'(v.m);
            slv_dly = v.dly; slv_swap = v.swap; bus.s_data_out = v.sdata;
            if (v.rd) begin
                bus.m_read_addr[mi*AW +: AW] = v.addr;
                bus.m_oe[mi] = 1'b1;
            end else begin
                bus.m_write_addr[mi*AW +: AW] = v.addr;
                bus.m_data_in[mi*DW +: DW]    = v.wdata;
                bus.m_be[mi*BW +: BW]         = v.be;
                bus.m_we[mi] = 1'b1;
            end
            observe(24);
            bus.m_oe = 2'b00; bus.m_we = 2'b00;
            chk($sformatf("v%0d_npulse", i), npulse, 1);
            chk($sformatf("v%0d_cyc", i), p_cyc[0], v.e_cyc);
            chk($sformatf("v%0d_valid", i), p_valid[0], v.rd ? v.e_mask : 2'b00);
            chk($sformatf("v%0d_wack", i), p_wack[0], v.rd ? 2'b00 : v.e_mask);
            if (v.rd) chk($sformatf("v%0d_data", i), p_data[0], v.e_data);
            chk($sformatf("v%0d_terr", i), p_terr[0], v.e_terr);
            chk($sformatf("v%0d_n_oe", i), n_oe, v.e_oe);
            chk($sformatf("v%0d_n_we", i), n_we, v.e_we);
            chk($sformatf("v%0d_stray", i), stray, 0);
            if (v.e_oe != 0) begin
                chk($sformatf("v%0d_oe_cyc", i), oe_cyc, 1);
                chk($sformatf("v%0d_oe_addr", i), oe_addr, v.addr);
            end
            if (v.e_we != 0) begin
                chk($sformatf("v%0d_we_cyc", i), we_cyc, 1);
                chk($sformatf("v%0d_we_addr", i), we_addr, v.addr);
                chk($sformatf("v%0d_we_data", i), we_data, v.wdata);
                chk($sformatf("v%0d_we_be", i), we_be, v.be);
            end
        end

        // reset while waiting on a silent slave, request held across reset
        slv_dly = 0; slv_swap = 1'b0; bus.s_data_out = 32'h600DCAFE;
        bus.m_read_addr[AW-1:0] = 22'h0ABCDE;
        bus.m_oe = 2'b01;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0; slv_dly = 1;
        observe(12);
        bus.m_oe = 2'b00;
        chk("midrst_npulse", npulse, 1);
        chk("midrst_cyc", p_cyc[0], 3);
        chk("midrst_valid", p_valid[0], 2'b01);
        chk("midrst_data", p_data[0], 32'h600DCAFE);
        chk("midrst_n_oe", n_oe, 1);

        // same master raises OE and WE together: write first, read on the next grant
        slv_dly = 1; bus.s_data_out = 32'hCAFEF00D;
        bus.m_read_addr[AW-1:0] = 22'h000300; bus.m_write_addr[AW-1:0] = 22'h000200;
        bus.m_data_in[DW-1:0] = 32'h89ABCDEF; bus.m_be[BW-1:0] = 4'hF;
        bus.m_oe = 2'b01; bus.m_we = 2'b01;
        observe(16);
        bus.m_oe = 2'b00; bus.m_we = 2'b00;
        chk("both_npulse", npulse, 2);
        chk("both_p0_cyc", p_cyc[0], 3);
        chk("both_p0_wack", p_wack[0], 2'b01);
        chk("both_p0_valid", p_valid[0], 2'b00);
        chk("both_p1_cyc", p_cyc[1], 7);
        chk("both_p1_valid", p_valid[1], 2'b01);
        chk("both_p1_data", p_data[1], 32'hCAFEF00D);
        chk("both_we_cyc", we_cyc, 1);
        chk("both_oe_cyc", oe_cyc, 5);
        chk("both_n_we", n_we, 1);
        chk("both_n_oe", n_oe, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
